// File: rtl/imem_loader.sv
// Y86-64 instruction memory with a byte-serial program loader in front of it.
// The loader streams a program in, then serves 10-byte fetch windows combinationally.
module imem_loader #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load_start,
    input  logic              i_in_valid,
    input  logic [7:0]        i_in_data,
    input  logic              i_in_last,
    output logic              o_in_ready,
    input  logic [63:0]       i_f_PC,
    output logic [79:0]       o_instr_bytes,
    output logic              o_imem_error,
    output logic              o_run,
    output logic              o_load_err,
    output logic [ADDR_W:0]   o_byte_count
);

    localparam int                CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(MEM_BYTES - 1);
    localparam logic [63:0]       PC_MAX   = 64'(MEM_BYTES - 10);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_OVF
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_in_ready;
    logic               r_run;
    logic               r_load_err;
    logic [CNT_W-1:0]   r_byte_count;
    logic [7:0]         r_mem [MEM_BYTES];

    logic               w_xfer;
    logic               w_err;
    logic [79:0]        w_window;

    // load_start beats a simultaneous byte: the byte is dropped, not written.
    assign w_xfer = r_in_ready & i_in_valid & ~i_load_start;

    always_comb begin
        w_state_nxt = r_state;
        if (i_load_start) begin
            w_state_nxt = S_LOAD;
        end else if (w_xfer) begin
            if (i_in_last) begin
                w_state_nxt = S_RUN;
            end else if (r_byte_count == LAST_IDX) begin
                w_state_nxt = S_OVF;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_in_ready   <= 1'b0;
            r_run        <= 1'b0;
            r_load_err   <= 1'b0;
            r_byte_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt == S_LOAD);
            r_run      <= (w_state_nxt == S_RUN);
            r_load_err <= (w_state_nxt == S_OVF);
            if (i_load_start) begin
                r_byte_count <= '0;
            end else if (w_xfer) begin
                r_byte_count <= r_byte_count + 1'b1;
            end
        end
    end

    // Storage is never cleared; byte_count masking alone defines visible data.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_xfer) begin
            r_mem[r_byte_count[ADDR_W-1:0]] <= i_in_data;
        end
    end

    assign w_err = (r_state != S_RUN) | (i_f_PC > PC_MAX);

    always_comb begin
        w_window = '0;
        for (int i = 0; i < 10; i++) begin
            if (!w_err && ((i_f_PC + 64'(i)) < 64'(r_byte_count))) begin
                w_window[8*i +: 8] = r_mem[i_f_PC[ADDR_W-1:0] + ADDR_W'(i)];
            end
        end
    end

    assign o_in_ready    = r_in_ready;
    assign o_run         = r_run;
    assign o_load_err    = r_load_err;
    assign o_byte_count  = r_byte_count;
    assign o_imem_error  = w_err;
    assign o_instr_bytes = w_window;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: a 1024-byte and a 16-byte instance
// are driven against a behavioural loader/memory model.
module tb_imem_loader;

    typedef logic [94:0] exp_t;

    localparam int ST_IDLE = 0;
    localparam int ST_LOAD = 1;
    localparam int ST_RUN  = 2;
    localparam int ST_OVF  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ls  [2];
    logic        vld [2];
    logic        lst [2];
    logic [7:0]  dat [2];
    logic [63:0] pc  [2];
    logic        chk;

    logic        m_rdy, m_err, m_run, m_lerr;
    logic [79:0] m_instr;
    logic [10:0] m_cnt;
    logic        s_rdy, s_err, s_run, s_lerr;
    logic [79:0] s_instr;
    logic [4:0]  s_cnt;

    int          n_chk  = 0;
    int          n_fail = 0;

    exp_t        exp_q[$];
    int          sel_q[$];
    string       name_q[$];

    int          ref_st   [2];
    int          ref_cnt  [2];
    bit          ref_lerr [2];
    logic [7:0]  ref_mem  [2][1024];
    int          memb     [2] = '{1024, 16};
    logic [7:0]  sbuf     [1024];

    always #5 clk = ~clk;

    imem_loader #(.MEM_BYTES(1024), .ADDR_W(10)) u_main (
        .i_clk(clk), .i_rst_n(rst_n), .i_load_start(ls[0]), .i_in_valid(vld[0]),
        .i_in_data(dat[0]), .i_in_last(lst[0]), .o_in_ready(m_rdy), .i_f_PC(pc[0]),
        .o_instr_bytes(m_instr), .o_imem_error(m_err), .o_run(m_run),
        .o_load_err(m_lerr), .o_byte_count(m_cnt)
    );

    imem_loader #(.MEM_BYTES(16), .ADDR_W(4)) u_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_load_start(ls[1]), .i_in_valid(vld[1]),
        .i_in_data(dat[1]), .i_in_last(lst[1]), .o_in_ready(s_rdy), .i_f_PC(pc[1]),
        .o_instr_bytes(s_instr), .o_imem_error(s_err), .o_run(s_run),
        .o_load_err(s_lerr), .o_byte_count(s_cnt)
    );

    // Monitor: pops one expectation each time the stimulus presents a fetch probe.
    always @(negedge clk) begin
        if (chk) begin
            exp_t  e;
            exp_t  a;
            int    s;
            string nm;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: probe with no expectation queued");
            end else begin
                e  = exp_q.pop_front();
                s  = sel_q.pop_front();
                nm = name_q.pop_front();
                if (s == 0) a = {m_instr, m_err, m_run, m_rdy, m_lerr, m_cnt};
                else        a = {s_instr, s_err, s_run, s_rdy, s_lerr, 6'b0, s_cnt};
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s: got bytes=%h err=%b run=%b rdy=%b lerr=%b cnt=%0d, want bytes=%h err=%b run=%b rdy=%b lerr=%b cnt=%0d",
                             nm, a[94:15], a[14], a[13], a[12], a[11], a[10:0],
                             e[94:15], e[14], e[13], e[12], e[11], e[10:0]);
                end
            end
        end
    end

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            ref_st[s]   = ST_IDLE;
            ref_cnt[s]  = 0;
            ref_lerr[s] = 1'b0;
        end
    endtask

    task automatic model_step(input int sel, input bit l, input bit v,
                              input logic [7:0] d, input bit last);
        if (l) begin
            ref_st[sel]   = ST_LOAD;
            ref_cnt[sel]  = 0;
            ref_lerr[sel] = 1'b0;
        end else if (ref_st[sel] == ST_LOAD && v) begin
            ref_mem[sel][ref_cnt[sel]] = d;
            ref_cnt[sel]++;
            if (last) begin
                ref_st[sel] = ST_RUN;
            end else if (ref_cnt[sel] == memb[sel]) begin
                ref_st[sel]   = ST_OVF;
                ref_lerr[sel] = 1'b1;
            end
        end
    endtask

    task automatic cycle(input int sel, input bit l, input bit v,
                         input logic [7:0] d, input bit last);
        ls[sel]  = l;
        vld[sel] = v;
        dat[sel] = d;
        lst[sel] = last;
        @(posedge clk);
        model_step(sel, l, v, d, last);
        #1;
        ls[sel]  = 1'b0;
        vld[sel] = 1'b0;
        lst[sel] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    // Offers sbuf[0..n-1]; with gaps, in_valid is dropped for random idle cycles.
    task automatic stream(input int sel, input int n, input bit last_final, input bit gaps);
        for (int k = 0; k < n; k++) begin
            int idle = 0;
            while (gaps && idle < 6 && $urandom_range(0, 2) == 0) begin
                cycle(sel, 1'b0, 1'b0, 8'($urandom), 1'b0);
                idle++;
            end
            cycle(sel, 1'b0, 1'b1, sbuf[k], last_final && (k == n - 1));
        end
    endtask

    task automatic check(input int sel, input logic [63:0] p, input string nm);
        logic [79:0] b = '0;
        logic [63:0] a;
        bit          err;
        err = (ref_st[sel] != ST_RUN) || (p > 64'(memb[sel] - 10));
        if (!err) begin
            for (int i = 0; i < 10; i++) begin
                a = p + 64'(i);
                if (a < 64'(ref_cnt[sel])) b[8*i +: 8] = ref_mem[sel][a[9:0]];
            end
        end
        pc[sel] = p;
        exp_q.push_back({b, err, ref_st[sel] == ST_RUN, ref_st[sel] == ST_LOAD,
                         ref_lerr[sel], 11'(ref_cnt[sel])});
        sel_q.push_back(sel);
        name_q.push_back(nm);
        chk = 1'b1;
        @(negedge clk);
        #1;
        chk = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b1;
        chk   = 1'b0;
        for (int s = 0; s < 2; s++) begin
            ls[s] = 1'b0; vld[s] = 1'b0; lst[s] = 1'b0; dat[s] = 8'h00; pc[s] = 64'd0;
            for (int j = 0; j < 1024; j++) ref_mem[s][j] = 8'h00;
        end
        model_reset();

        do_reset();
        check(0, 64'd0, "reset_main");
        check(1, 64'd0, "reset_small");
        cycle(0, 1'b1, 1'b0, 8'h00, 1'b0);
        check(0, 64'd0, "start_ready");

        // Nominal program.
        {sbuf[0], sbuf[1], sbuf[2], sbuf[3], sbuf[4], sbuf[5]} = {8'h30, 8'hF7, 8'h00, 8'h01, 8'h02, 8'h03};
        {sbuf[6], sbuf[7], sbuf[8], sbuf[9], sbuf[10]}         = {8'h04, 8'h05, 8'h06, 8'h07, 8'h00};
        stream(0, 11, 1'b1, 1'b0);
        check(0, 64'd0, "nominal_pc0");
        n_chk++;
        if (m_instr !== 80'h0706050403020100F730 || m_cnt !== 11'd11) begin
            n_fail++;
            $display("FAIL nominal_literal: got bytes=%h cnt=%0d, want bytes=0706050403020100f730 cnt=11", m_instr, m_cnt);
        end
        check(0, 64'd10, "nominal_pc10");
        check(0, 64'd5, "nominal_pc5_partial");
        check(0, 64'd1014, "bound_1014");
        check(0, 64'd1015, "bound_1015");
        check(0, 64'hFFFF_FFFF_FFFF_FFFE, "bound_nowrap");

        // Reload colliding with an offered byte.
        cycle(0, 1'b1, 1'b1, 8'hAA, 1'b0);
        check(0, 64'd0, "collision_run");
        sbuf[0] = 8'h10;
        stream(0, 1, 1'b1, 1'b0);
        check(0, 64'd0, "reload_one_byte");

        // Backpressure with random valid gaps.
        cycle(0, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 5; k++) sbuf[k] = 8'($urandom);
        stream(0, 3, 1'b0, 1'b1);
        check(0, 64'd0, "bp_midload");
        for (int k = 0; k < 2; k++) sbuf[k] = sbuf[k + 3];
        stream(0, 2, 1'b1, 1'b1);
        check(0, 64'd0, "bp_loaded");

        // Overflow on the 16-byte instance, then refill exactly with in_last.
        cycle(1, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 16; k++) sbuf[k] = 8'($urandom);
        stream(1, 16, 1'b0, 1'b1);
        check(1, 64'd0, "ovf_state");
        cycle(1, 1'b0, 1'b1, 8'h55, 1'b1);
        check(1, 64'd0, "ovf_ignores_byte");
        cycle(1, 1'b1, 1'b0, 8'h00, 1'b0);
        check(1, 64'd0, "ovf_restart");
        for (int k = 0; k < 16; k++) sbuf[k] = 8'($urandom);
        stream(1, 16, 1'b1, 1'b1);
        check(1, 64'd0, "fill_last_run");
        check(1, 64'd6, "small_bound_6");
        check(1, 64'd7, "small_bound_7");

        // Random programs, some with a mid-stream restart.
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 60);
            cycle(0, 1'b1, 1'b0, 8'h00, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < n; k++) sbuf[k] = 8'($urandom);
                stream(0, (n + 1) / 2, 1'b0, 1'b1);
                cycle(0, 1'b1, 1'b1, 8'($urandom), 1'b0);
                check(0, 64'd0, "rand_restart");
            end
            for (int k = 0; k < n; k++) sbuf[k] = 8'($urandom);
            stream(0, n, 1'b1, 1'b1);
            check(0, 64'd0, "rand_pc0");
            check(0, 64'(n - 1), "rand_tail");
            check(0, 64'($urandom_range(0, n + 3)), "rand_pc");
        end

        // Full-size program reaching the upper fetch bound.
        cycle(0, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 1024; k++) sbuf[k] = 8'($urandom);
        stream(0, 1024, 1'b1, 1'b0);
        check(0, 64'd1014, "full_1014");
        check(0, 64'd1000, "full_1000");
        check(0, 64'd1015, "full_1015");

        // Full-size overflow on the large instance.
        cycle(0, 1'b1, 1'b0, 8'h00, 1'b0);
        stream(0, 1024, 1'b0, 1'b0);
        check(0, 64'd0, "main_ovf");

        // Reset in the middle of a load.
        cycle(0, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) sbuf[k] = 8'($urandom);
        stream(0, 3, 1'b0, 1'b0);
        do_reset();
        check(0, 64'd0, "reset_midload");
        cycle(0, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 2; k++) sbuf[k] = 8'($urandom);
        stream(0, 2, 1'b1, 1'b1);
        check(0, 64'd0, "after_reset_load");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
